// File: rtl/pcie_dl_pkg.sv
// Data link layer status shared by the transmit and receive stream muxes.
package pcie_dl_pkg;

    typedef enum logic [1:0] {
        DL_INACTIVE = 2'd0,
        DL_INIT     = 2'd1,
        DL_ACTIVE   = 2'd2
    } pcie_dl_status_e;

endpackage

// File: rtl/axis_user_mux.sv
// Transmit-side TLP/DLLP stream merge. Packet-atomic arbitration with DLLP
// priority and a TLP starvation guard, tuser type stamping (bit1 = TLP,
// bit0 = DLLP) and a two-entry skid buffer toward the framing path.
module axis_user_mux
    import pcie_dl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int unsigned KEEP_WIDTH     = STRB_WIDTH,
    parameter int unsigned USER_WIDTH     = 2,
    parameter int unsigned MAX_DLLP_BURST = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  pcie_dl_status_e       link_status_i,

    input  logic [DATA_WIDTH-1:0] s_tlp_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_tlp_axis_tkeep,
    input  logic                  s_tlp_axis_tvalid,
    input  logic                  s_tlp_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_tlp_axis_tuser,
    output logic                  s_tlp_axis_tready,

    input  logic [DATA_WIDTH-1:0] s_dllp_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_dllp_axis_tkeep,
    input  logic                  s_dllp_axis_tvalid,
    input  logic                  s_dllp_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_dllp_axis_tuser,
    output logic                  s_dllp_axis_tready,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    input  logic                  m_axis_tready
);

    localparam logic [7:0] LP_BURST_MAX = 8'(MAX_DLLP_BURST);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TLP  = 2'd1,
        ST_DLLP = 2'd2
    } state_e;

    state_e                r_state;
    logic [7:0]            r_burst_cnt;

    // skid buffer: main (output) register plus temp register
    logic                  r_int_ready;
    logic                  r_m_valid;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic [KEEP_WIDTH-1:0] r_m_keep;
    logic                  r_m_last;
    logic [USER_WIDTH-1:0] r_m_user;
    logic                  r_t_valid;
    logic [DATA_WIDTH-1:0] r_t_data;
    logic [KEEP_WIDTH-1:0] r_t_keep;
    logic                  r_t_last;
    logic [USER_WIDTH-1:0] r_t_user;

    logic                  w_tlp_elig;
    logic                  w_burst_max;
    logic                  w_sel_valid;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [KEEP_WIDTH-1:0] w_sel_keep;
    logic                  w_sel_last;
    logic [USER_WIDTH-1:0] w_sel_user;
    logic                  w_accept;
    logic                  w_ready_early;

    assign w_tlp_elig  = s_tlp_axis_tvalid && (link_status_i == DL_ACTIVE);
    assign w_burst_max = (r_burst_cnt == LP_BURST_MAX);

    // Granted input goes straight to the skid buffer; idle state has no ready.
    assign s_tlp_axis_tready  = (r_state == ST_TLP)  && r_int_ready;
    assign s_dllp_axis_tready = (r_state == ST_DLLP) && r_int_ready;

    // Select the granted source and stamp its tuser type bits.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        w_sel_keep  = '0;
        w_sel_last  = 1'b0;
        w_sel_user  = '0;
        case (r_state)
            ST_TLP: begin
                w_sel_valid      = s_tlp_axis_tvalid;
                w_sel_data       = s_tlp_axis_tdata;
                w_sel_keep       = s_tlp_axis_tkeep;
                w_sel_last       = s_tlp_axis_tlast;
                w_sel_user       = s_tlp_axis_tuser;
                w_sel_user[1:0]  = 2'b10;
            end
            ST_DLLP: begin
                w_sel_valid      = s_dllp_axis_tvalid;
                w_sel_data       = s_dllp_axis_tdata;
                w_sel_keep       = s_dllp_axis_tkeep;
                w_sel_last       = s_dllp_axis_tlast;
                w_sel_user       = s_dllp_axis_tuser;
                w_sel_user[1:0]  = 2'b01;
            end
            default: ;
        endcase
    end

    assign w_accept = w_sel_valid && r_int_ready;

    // Next-cycle ready: free while the temp slot stays empty after this cycle.
    always_comb begin
        w_ready_early = m_axis_tready || (!r_t_valid && (!r_m_valid || !w_accept));
    end

    // Arbiter: registered grant, packet lock until tlast, starvation counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (s_dllp_axis_tvalid && !(w_tlp_elig && w_burst_max)) begin
                        r_state <= ST_DLLP;
                    end else if (w_tlp_elig) begin
                        r_state     <= ST_TLP;
                        r_burst_cnt <= '0;
                    end
                end
                ST_TLP: begin
                    if (w_accept && s_tlp_axis_tlast) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DLLP: begin
                    if (w_accept && s_dllp_axis_tlast) begin
                        r_state <= ST_IDLE;
                        if (!w_tlp_elig) begin
                            r_burst_cnt <= '0;
                        end else if (!w_burst_max) begin
                            r_burst_cnt <= r_burst_cnt + 8'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Skid buffer: the temp slot only fills when the output stalls while an
    // already-promised beat arrives; it drains back into main before new input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_int_ready <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_m_keep    <= '0;
            r_m_last    <= 1'b0;
            r_m_user    <= '0;
            r_t_valid   <= 1'b0;
            r_t_data    <= '0;
            r_t_keep    <= '0;
            r_t_last    <= 1'b0;
            r_t_user    <= '0;
        end else begin
            r_int_ready <= w_ready_early;
            if (r_int_ready) begin
                if (m_axis_tready || !r_m_valid) begin
                    r_m_valid <= w_accept;
                    if (w_accept) begin
                        r_m_data <= w_sel_data;
                        r_m_keep <= w_sel_keep;
                        r_m_last <= w_sel_last;
                        r_m_user <= w_sel_user;
                    end
                end else if (w_accept) begin
                    r_t_valid <= 1'b1;
                    r_t_data  <= w_sel_data;
                    r_t_keep  <= w_sel_keep;
                    r_t_last  <= w_sel_last;
                    r_t_user  <= w_sel_user;
                end
            end else if (m_axis_tready) begin
                r_m_valid <= r_t_valid;
                r_m_data  <= r_t_data;
                r_m_keep  <= r_t_keep;
                r_m_last  <= r_t_last;
                r_m_user  <= r_t_user;
                r_t_valid <= 1'b0;
            end
        end
    end

    assign m_axis_tvalid = r_m_valid;
    assign m_axis_tdata  = r_m_data;
    assign m_axis_tkeep  = r_m_keep;
    assign m_axis_tlast  = r_m_last;
    assign m_axis_tuser  = r_m_user;

endmodule

// File: tb/tb_axis_user_mux.sv
// Directed bench for axis_user_mux: DLLP/TLP only, arbitration order,
// starvation guard, link gating, random backpressure and mid-packet reset.
module tb_axis_user_mux;
    import pcie_dl_pkg::*;

    localparam int LIMIT = 300;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic [3:0]  u;
        int          c;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    pcie_dl_status_e link;
    logic [31:0] t_data, d_data, m_data;
    logic [3:0]  t_keep, d_keep, m_keep;
    logic [3:0]  t_user, d_user, m_user;
    logic        t_valid, t_last, t_ready;
    logic        d_valid, d_last, d_ready;
    logic        m_valid, m_last, m_ready;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int atom_viol = 0;
    int both_viol = 0;
    int link_viol = 0;
    logic       open_pkt = 1'b0;
    logic [1:0] open_ty = 2'b00;

    beat_t obs[$];
    beat_t exp_tlp[$];
    beat_t exp_dl[$];
    int    acc_dl[$];

    axis_user_mux #(
        .DATA_WIDTH(32),
        .USER_WIDTH(4),
        .MAX_DLLP_BURST(4)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .link_status_i(link),
        .s_tlp_axis_tdata(t_data),
        .s_tlp_axis_tkeep(t_keep),
        .s_tlp_axis_tvalid(t_valid),
        .s_tlp_axis_tlast(t_last),
        .s_tlp_axis_tuser(t_user),
        .s_tlp_axis_tready(t_ready),
        .s_dllp_axis_tdata(d_data),
        .s_dllp_axis_tkeep(d_keep),
        .s_dllp_axis_tvalid(d_valid),
        .s_dllp_axis_tlast(d_last),
        .s_dllp_axis_tuser(d_user),
        .s_dllp_axis_tready(d_ready),
        .m_axis_tdata(m_data),
        .m_axis_tkeep(m_keep),
        .m_axis_tvalid(m_valid),
        .m_axis_tlast(m_last),
        .m_axis_tuser(m_user),
        .m_axis_tready(m_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor plus always-on protocol watchers, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            open_pkt <= 1'b0;
        end else if (m_valid && m_ready) begin
            obs.push_back('{d: m_data, k: m_keep, l: m_last, u: m_user, c: cyc});
            if (open_pkt && (m_user[1:0] != open_ty)) atom_viol <= atom_viol + 1;
            open_pkt <= !m_last;
            open_ty  <= m_user[1:0];
        end
        if (t_ready && d_ready) both_viol <= both_viol + 1;
        if (link != DL_ACTIVE && t_ready) link_viol <= link_viol + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, need completion", $time);
        $fatal(1);
    end

    function automatic beat_t mk(input logic [31:0] d, input logic [3:0] k,
                                 input logic l, input logic [3:0] u);
        beat_t b;
        b.d = d; b.k = k; b.l = l; b.u = u; b.c = 0;
        return b;
    endfunction

    task automatic send_tlp(input logic [31:0] base, input logic [31:0] step,
                            input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            bit ok;
            if (gaps && $urandom_range(0, 1) == 1) begin
                t_valid = 1'b0;
                @(posedge clk); #1;
            end
            t_data  = base + step * i;
            t_last  = (i == n - 1);
            t_keep  = t_last ? 4'h7 : 4'hF;
            t_user  = 4'b1011;
            t_valid = 1'b1;
            exp_tlp.push_back(mk(t_data, t_keep, t_last, 4'b1010));
            ok = 1'b0;
            for (int w = 0; w < LIMIT; w++) begin
                @(negedge clk);
                if (t_ready) begin ok = 1'b1; break; end
            end
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL tlp_handshake: ready stayed 0 for %0d cycles on data %h, need 1", LIMIT, t_data);
                t_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        t_valid = 1'b0;
        t_last  = 1'b0;
    endtask

    task automatic send_dllp(input logic [31:0] d);
        bit ok;
        d_data  = d;
        d_keep  = 4'hF;
        d_last  = 1'b1;
        d_user  = 4'b0110;
        d_valid = 1'b1;
        exp_dl.push_back(mk(d, 4'hF, 1'b1, 4'b0101));
        ok = 1'b0;
        for (int w = 0; w < LIMIT; w++) begin
            @(negedge clk);
            if (d_ready) begin ok = 1'b1; break; end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL dllp_handshake: ready stayed 0 for %0d cycles on data %h, need 1", LIMIT, d);
        end else begin
            acc_dl.push_back(cyc);
            @(posedge clk); #1;
        end
        d_valid = 1'b0;
        d_last  = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid got %b need 0", m_valid); end
        tests++; if (m_data !== 32'h0) begin fails++; $display("FAIL reset_m_data got %h need 0", m_data); end
        tests++; if (m_keep !== 4'h0) begin fails++; $display("FAIL reset_m_keep got %h need 0", m_keep); end
        tests++; if (m_last !== 1'b0) begin fails++; $display("FAIL reset_m_last got %b need 0", m_last); end
        tests++; if (m_user !== 4'h0) begin fails++; $display("FAIL reset_m_user got %h need 0", m_user); end
        tests++; if (t_ready !== 1'b0) begin fails++; $display("FAIL reset_tlp_ready got %b need 0", t_ready); end
        tests++; if (d_ready !== 1'b0) begin fails++; $display("FAIL reset_dllp_ready got %b need 0", d_ready); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (t_ready !== 1'b0 || d_ready !== 1'b0) begin
            fails++; $display("FAIL idle_ready got tlp=%b dllp=%b need 0 0", t_ready, d_ready);
        end
    endtask

    task automatic test_dllp_only();
        beat_t e[$];
        obs.delete(); acc_dl.delete();
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            send_dllp(32'h0000_00AA + i);
            e.push_back(mk(32'h0000_00AA + i, 4'hF, 1'b1, 4'b0101));
        end
        repeat (3) @(negedge clk);
        tests++; if (obs.size() != 3) begin fails++; $display("FAIL dllp_only_count got %0d need 3", obs.size()); end
        for (int i = 0; i < 3 && i < obs.size(); i++) begin
            tests++;
            if (obs[i].d !== e[i].d || obs[i].k !== e[i].k || obs[i].l !== e[i].l || obs[i].u !== e[i].u) begin
                fails++;
                $display("FAIL dllp_only_beat%0d got d=%h k=%h l=%b u=%h need d=%h k=%h l=%b u=%h",
                         i, obs[i].d, obs[i].k, obs[i].l, obs[i].u, e[i].d, e[i].k, e[i].l, e[i].u);
            end
            tests++;
            if (i < acc_dl.size() && obs[i].c - acc_dl[i] !== 1) begin
                fails++; $display("FAIL dllp_latency%0d got %0d need 1", i, obs[i].c - acc_dl[i]);
            end
        end
        for (int i = 1; i < 3 && i < acc_dl.size(); i++) begin
            tests++;
            if (acc_dl[i] - acc_dl[i-1] !== 2) begin
                fails++; $display("FAIL dllp_spacing%0d got %0d need 2", i, acc_dl[i] - acc_dl[i-1]);
            end
        end
    endtask

    task automatic test_tlp_only();
        beat_t e[$];
        obs.delete();
        for (int i = 0; i < 4; i++)
            e.push_back(mk(32'h11 * (i + 1), (i == 3) ? 4'h7 : 4'hF, i == 3, 4'b1010));
        send_tlp(32'h11, 32'h11, 4, 1'b0);
        repeat (3) @(negedge clk);
        tests++; if (obs.size() != 4) begin fails++; $display("FAIL tlp_only_count got %0d need 4", obs.size()); end
        for (int i = 0; i < 4 && i < obs.size(); i++) begin
            tests++;
            if (obs[i].d !== e[i].d || obs[i].k !== e[i].k || obs[i].l !== e[i].l || obs[i].u !== e[i].u) begin
                fails++;
                $display("FAIL tlp_only_beat%0d got d=%h k=%h l=%b u=%h need d=%h k=%h l=%b u=%h",
                         i, obs[i].d, obs[i].k, obs[i].l, obs[i].u, e[i].d, e[i].k, e[i].l, e[i].u);
            end
        end
    endtask

    task automatic test_simultaneous();
        beat_t e[$];
        obs.delete();
        e.push_back(mk(32'hD1, 4'hF, 1'b1, 4'b0101));
        for (int i = 0; i < 4; i++)
            e.push_back(mk(32'h101 + i, (i == 3) ? 4'h7 : 4'hF, i == 3, 4'b1010));
        e.push_back(mk(32'hD2, 4'hF, 1'b1, 4'b0101));
        @(posedge clk); #1;
        fork
            send_tlp(32'h101, 32'h1, 4, 1'b0);
            begin
                send_dllp(32'hD1);
                repeat (3) @(posedge clk);
                #1;
                send_dllp(32'hD2);
            end
        join
        repeat (3) @(negedge clk);
        tests++; if (obs.size() != 6) begin fails++; $display("FAIL simul_count got %0d need 6", obs.size()); end
        for (int i = 0; i < 6 && i < obs.size(); i++) begin
            tests++;
            if (obs[i].d !== e[i].d || obs[i].k !== e[i].k || obs[i].l !== e[i].l || obs[i].u !== e[i].u) begin
                fails++;
                $display("FAIL simul_beat%0d got d=%h k=%h l=%b u=%h need d=%h k=%h l=%b u=%h",
                         i, obs[i].d, obs[i].k, obs[i].l, obs[i].u, e[i].d, e[i].k, e[i].l, e[i].u);
            end
        end
    endtask

    task automatic test_starvation();
        beat_t e[$];
        obs.delete();
        for (int i = 0; i < 4; i++) e.push_back(mk(32'hE1 + i, 4'hF, 1'b1, 4'b0101));
        e.push_back(mk(32'hF1, 4'hF, 1'b0, 4'b1010));
        e.push_back(mk(32'hF2, 4'h7, 1'b1, 4'b1010));
        for (int i = 4; i < 9; i++) e.push_back(mk(32'hE1 + i, 4'hF, 1'b1, 4'b0101));
        @(posedge clk); #1;
        fork
            send_tlp(32'hF1, 32'h1, 2, 1'b0);
            for (int i = 0; i < 9; i++) send_dllp(32'hE1 + i);
        join
        repeat (3) @(negedge clk);
        tests++; if (obs.size() != 11) begin fails++; $display("FAIL starve_count got %0d need 11", obs.size()); end
        for (int i = 0; i < 11 && i < obs.size(); i++) begin
            tests++;
            if (obs[i].d !== e[i].d || obs[i].k !== e[i].k || obs[i].l !== e[i].l || obs[i].u !== e[i].u) begin
                fails++;
                $display("FAIL starve_beat%0d got d=%h k=%h l=%b u=%h need d=%h k=%h l=%b u=%h",
                         i, obs[i].d, obs[i].k, obs[i].l, obs[i].u, e[i].d, e[i].k, e[i].l, e[i].u);
            end
        end
    endtask

    task automatic test_link();
        beat_t e[$];
        obs.delete();
        e.push_back(mk(32'hD5, 4'hF, 1'b1, 4'b0101));
        e.push_back(mk(32'hD6, 4'hF, 1'b1, 4'b0101));
        e.push_back(mk(32'h301, 4'hF, 1'b0, 4'b1010));
        e.push_back(mk(32'h302, 4'h7, 1'b1, 4'b1010));
        @(posedge clk); #1;
        link = DL_INACTIVE;
        fork
            send_tlp(32'h301, 32'h1, 2, 1'b0);
            begin
                send_dllp(32'hD5);
                send_dllp(32'hD6);
                repeat (8) @(posedge clk);
                #1;
                link = DL_ACTIVE;
            end
        join
        repeat (3) @(negedge clk);
        tests++; if (link_viol !== 0) begin fails++; $display("FAIL link_tlp_ready got %0d ready cycles while down need 0", link_viol); end
        tests++; if (obs.size() != 4) begin fails++; $display("FAIL link_count got %0d need 4", obs.size()); end
        for (int i = 0; i < 4 && i < obs.size(); i++) begin
            tests++;
            if (obs[i].d !== e[i].d || obs[i].k !== e[i].k || obs[i].l !== e[i].l || obs[i].u !== e[i].u) begin
                fails++;
                $display("FAIL link_beat%0d got d=%h k=%h l=%b u=%h need d=%h k=%h l=%b u=%h",
                         i, obs[i].d, obs[i].k, obs[i].l, obs[i].u, e[i].d, e[i].k, e[i].l, e[i].u);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit tdone, ddone;
        int ti, di, tbad, dbad, other, waitc;
        obs.delete(); exp_tlp.delete(); exp_dl.delete();
        tdone = 1'b0; ddone = 1'b0;
        @(posedge clk); #1;
        fork
            begin
                for (int p = 0; p < 50; p++)
                    send_tlp(32'hA000_0000 + (p << 4), 32'h1, $urandom_range(1, 4), 1'b1);
                tdone = 1'b1;
            end
            begin
                for (int p = 0; p < 50; p++) begin
                    send_dllp(32'hD000_0000 + p);
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                end
                ddone = 1'b1;
            end
            while (!(tdone && ddone)) begin
                @(posedge clk); #1;
                m_ready = ($urandom_range(0, 1) == 1);
            end
        join
        m_ready = 1'b1;
        waitc = 0;
        while (obs.size() < exp_tlp.size() + exp_dl.size() && waitc < 50) begin
            @(negedge clk); waitc++;
        end
        repeat (2) @(negedge clk);
        tests++;
        if (obs.size() != exp_tlp.size() + exp_dl.size()) begin
            fails++; $display("FAIL bp_count got %0d need %0d", obs.size(), exp_tlp.size() + exp_dl.size());
        end
        ti = 0; di = 0; tbad = 0; dbad = 0; other = 0;
        foreach (obs[i]) begin
            if (obs[i].u[1:0] == 2'b10) begin
                if (ti >= exp_tlp.size() || obs[i].d !== exp_tlp[ti].d || obs[i].k !== exp_tlp[ti].k ||
                    obs[i].l !== exp_tlp[ti].l || obs[i].u !== exp_tlp[ti].u) tbad++;
                ti++;
            end else if (obs[i].u[1:0] == 2'b01) begin
                if (di >= exp_dl.size() || obs[i].d !== exp_dl[di].d || obs[i].l !== exp_dl[di].l ||
                    obs[i].u !== exp_dl[di].u) dbad++;
                di++;
            end else begin
                other++;
            end
        end
        tests++; if (tbad !== 0 || ti != exp_tlp.size()) begin fails++; $display("FAIL bp_tlp_stream got %0d bad of %0d need 0 bad of %0d", tbad, ti, exp_tlp.size()); end
        tests++; if (dbad !== 0 || di != exp_dl.size()) begin fails++; $display("FAIL bp_dllp_stream got %0d bad of %0d need 0 bad of %0d", dbad, di, exp_dl.size()); end
        tests++; if (other !== 0) begin fails++; $display("FAIL bp_type_bits got %0d unstamped beats need 0", other); end
        tests++; if (atom_viol !== 0) begin fails++; $display("FAIL bp_atomic got %0d interleaves need 0", atom_viol); end
        tests++; if (both_viol !== 0) begin fails++; $display("FAIL bp_both_ready got %0d cycles need 0", both_viol); end
    endtask

    task automatic test_reset_mid();
        beat_t e[$];
        int w;
        e.push_back(mk(32'hE0, 4'hF, 1'b1, 4'b0101));
        e.push_back(mk(32'h501, 4'hF, 1'b0, 4'b1010));
        e.push_back(mk(32'h502, 4'h7, 1'b1, 4'b1010));
        @(posedge clk); #1;
        t_data = 32'h401; t_keep = 4'hF; t_last = 1'b0; t_user = 4'b1011; t_valid = 1'b1;
        w = 0;
        do begin @(negedge clk); w++; end while (!(m_valid && obs.size() >= 2) && w < 40);
        #1 rst_n = 1'b0;
        #1;
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL rstmid_m_valid got %b need 0", m_valid); end
        tests++; if (m_data !== 32'h0 || m_last !== 1'b0) begin fails++; $display("FAIL rstmid_m_data got %h/%b need 0/0", m_data, m_last); end
        tests++; if (t_ready !== 1'b0) begin fails++; $display("FAIL rstmid_tlp_ready got %b need 0", t_ready); end
        t_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        obs.delete();
        repeat (2) @(negedge clk);
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL rstmid_no_residue got valid=%b need 0", m_valid); end
        @(posedge clk); #1;
        send_dllp(32'hE0);
        send_tlp(32'h501, 32'h1, 2, 1'b0);
        repeat (3) @(negedge clk);
        tests++; if (obs.size() != 3) begin fails++; $display("FAIL rstmid_count got %0d need 3", obs.size()); end
        for (int i = 0; i < 3 && i < obs.size(); i++) begin
            tests++;
            if (obs[i].d !== e[i].d || obs[i].k !== e[i].k || obs[i].l !== e[i].l || obs[i].u !== e[i].u) begin
                fails++;
                $display("FAIL rstmid_beat%0d got d=%h k=%h l=%b u=%h need d=%h k=%h l=%b u=%h",
                         i, obs[i].d, obs[i].k, obs[i].l, obs[i].u, e[i].d, e[i].k, e[i].l, e[i].u);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        link    = DL_ACTIVE;
        m_ready = 1'b1;
        t_data = '0; t_keep = '0; t_valid = 1'b0; t_last = 1'b0; t_user = '0;
        d_data = '0; d_keep = '0; d_valid = 1'b0; d_last = 1'b0; d_user = '0;
        test_reset();
        test_dllp_only();
        test_tlp_only();
        test_simultaneous();
        test_starvation();
        test_link();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axis_user_mux.md
Name: axis_user_mux

Overview:
- Transmit-side counterpart of the receive-path TLP/DLLP user-flag demux.
- Merges a TLP AXI-Stream and a DLLP AXI-Stream into one packet stream toward the framing/PHY transmit path.
- Arbitration is packet-atomic with DLLP priority and a TLP starvation guard.
- Each outgoing beat's tuser type bits are stamped (bit1 = TLP, bit0 = DLLP) so downstream logic can split the stream the same way the receive demux does.

Parameters:
- DATA_WIDTH, 32, tdata width.
- STRB_WIDTH, DATA_WIDTH/8, strobe width.
- KEEP_WIDTH, STRB_WIDTH, tkeep width.
- USER_WIDTH, 2, tuser width; must be >= 2.
- MAX_DLLP_BURST, 4, consecutive DLLP packets granted while a TLP waits before TLP is forced; range 1..255.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- link_status_i  in  pcie_dl_status_e  data link status; TLP grants allowed only when DL_ACTIVE.
- s_tlp_axis_tdata  in  DATA_WIDTH  TLP data.
- s_tlp_axis_tkeep  in  KEEP_WIDTH  TLP keep.
- s_tlp_axis_tvalid  in  1  TLP valid.
- s_tlp_axis_tlast  in  1  TLP last.
- s_tlp_axis_tuser  in  USER_WIDTH  TLP user.
- s_tlp_axis_tready  out  1  TLP ready.
- s_dllp_axis_tdata  in  DATA_WIDTH  DLLP data.
- s_dllp_axis_tkeep  in  KEEP_WIDTH  DLLP keep.
- s_dllp_axis_tvalid  in  1  DLLP valid.
- s_dllp_axis_tlast  in  1  DLLP last.
- s_dllp_axis_tuser  in  USER_WIDTH  DLLP user.
- s_dllp_axis_tready  out  1  DLLP ready.
- m_axis_tdata  out  DATA_WIDTH  merged data.
- m_axis_tkeep  out  KEEP_WIDTH  merged keep.
- m_axis_tvalid  out  1  merged valid.
- m_axis_tlast  out  1  merged last.
- m_axis_tuser  out  USER_WIDTH  merged user with type bits stamped.
- m_axis_tready  in  1  merged ready.

Behaviour:
Reset:
- All m_axis_* outputs 0; both s_*_tready 0.
- State ST_IDLE; starvation counter 0; skid storage empty.
- Reset asserted mid-packet discards the packet in flight and any buffered beats; no tlast is emitted for it.

Output stage:
- Two-entry skid buffer (main + temp register).
- Internal ready = registered "temp empty", so m_axis_tready has no combinational path to s_*_tready.
- Latency: 1 cycle from an accepted input beat to m_axis_tvalid.
- Full throughput: 1 beat/cycle when m_axis_tready stays high.
- Beats are never dropped, duplicated or reordered.

FSM states ST_IDLE, ST_TLP, ST_DLLP:
- ST_IDLE: no input ready. On the next clock:
  - ST_DLLP if DLLP valid and not (TLP eligible and counter == MAX_DLLP_BURST).
  - Else ST_TLP if TLP eligible.
  - TLP eligible = s_tlp_axis_tvalid && link_status_i == DL_ACTIVE.
  - Grant takes one idle cycle (registered decision).
- ST_TLP:
  - s_tlp_axis_tready = internal ready; DLLP ready 0.
  - On accepted beat with tlast -> ST_IDLE.
  - Counter cleared on entry.
- ST_DLLP:
  - s_dllp_axis_tready = internal ready; TLP ready 0.
  - On accepted beat with tlast -> ST_IDLE.
  - On packet completion, counter += 1 (saturating at MAX_DLLP_BURST) if TLP eligible at that cycle, else counter cleared.

Locking and link status:
- A granted packet is never preempted.
- link_status_i leaving DL_ACTIVE mid-TLP does not abort it; the TLP completes, and no further TLP is granted until DL_ACTIVE returns.

tuser stamping:
- Bits [USER_WIDTH-1:2] pass through from the selected input.
- bit1 = 1, bit0 = 0 for TLP beats; bit1 = 0, bit0 = 1 for DLLP beats.

Data path:
- tdata, tkeep and tlast pass through unchanged.
- tvalid deasserted mid-packet on the granted input simply stalls the output; the lock is held.

Test Plan:
- DLLP-only traffic: 1-beat DLLPs (tdata 0x0000_00AA) back-to-back with m_axis_tready = 1 -> each appears 1 cycle after acceptance; m_axis_tuser[1:0] = 2'b01; one idle cycle between packets.
- TLP-only traffic: 4-beat TLP (0x11..0x44), DL_ACTIVE -> 4 beats in order; tlast on beat 4 only; m_axis_tuser[1:0] = 2'b10.
- Simultaneous arrival: TLP and DLLP valid together with counter 0 -> DLLP first, then TLP; a DLLP arriving during the TLP waits for the TLP's tlast.
- Starvation guard: continuous DLLP supply, TLP pending, MAX_DLLP_BURST = 4 -> exactly 4 DLLPs, then 1 TLP, then DLLPs resume.
- Backpressure: random m_axis_tready at 50% over 100 mixed packets -> scoreboard matches exactly; no beat loss; s_*_tready never asserted for the non-granted input.
- Link and reset: link_status_i not DL_ACTIVE with TLP valid -> s_tlp_axis_tready stays 0 and only DLLPs pass. Separately, rst_ni pulsed low mid-TLP -> m_axis_tvalid = 0 immediately (asynchronously); after release, state ST_IDLE and next grant is fresh.
